hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. It keeps its own shadow copy of the destination-register state for the E, M and W stages. Each cycle it produces the one-hot forwarding selects consumed by the decode-stage forwarding mux: ALUOutE, ALUOutM, ResultW or the register file. It also raises stall/flush for load-use hazards and for a multi-cycle divider tracked by an internal busy counter.

## Interface
Parameters:
- DIV_LATENCY, 8, cycles the divider occupies HI/LO after issue (1..15)
- CNT_W, 4, width of the divide busy counter

Ports:
- clk  in  1  rising-edge clock, sole clock
- reset  in  1  synchronous, active-high
- ValidD  in  1  D-stage slot holds a real instruction
- RsD, RtD  in  5 each  D-stage source register numbers
- UsesRsD, UsesRtD  in  1 each  instruction actually reads Rs / Rt
- RegWriteD  in  1  D instruction writes a GPR
- MemtoRegD  in  1  D instruction is a load
- WriteRegD  in  5  D instruction destination register
- DivStartD  in  1  D instruction issues a divide/multiply to HI/LO
- UsesHiLoD  in  1  D instruction reads HI/LO (mfhi/mflo)
- FlushDIn  in  1  branch redirect: kill the D-stage instruction
- ForwardADN1, ForwardBDN1  out  1 each  select ALUOutE for RD1D / RD2D
- ForwardAD, ForwardBD  out  1 each  select ALUOutM
- ForwardADN2, ForwardBDN2  out  1 each  select ResultW
- StallF, StallD  out  1 each  hold PC and IF/ID register
- FlushE  out  1  insert bubble into ID/EX
- DivBusy  out  1  divide counter non-zero

## Operation
- Shadow registers per stage X in {E,M,W}: ValidX, RegWriteX, MemtoRegX, WriteRegX[4:0].
- Each edge: M<=E, W<=M. E<=D fields when Stall=0 and FlushDIn=0. Otherwise ValidE<=0 and RegWriteE<=0 (bubble).
- Match for source S vs stage X: ValidX & RegWriteX & (WriteRegX==S) & (S!=0) & UsesS & ValidD.
- Forward select per operand is youngest-first and one-hot:
  - E match & !MemtoRegE -> N1.
  - Else E match & MemtoRegE -> no forward, load-use stall.
  - Else M match & !MemtoRegM -> AD.
  - Else M match & MemtoRegM -> no forward, stall. ALUOutM is an address, not load data.
  - Else W match -> N2.
  - Else all 0 (register file).
- At most one of N1/AD/N2 is high per operand. This holds even when the stall is asserted.
- Divide counter:
  - DivStartD & ValidD & !Stall & !FlushDIn loads DIV_LATENCY.
  - Otherwise the counter decrements when non-zero and saturates at 0.
  - DivBusy = (cnt != 0).
- Stall = load-use(A or B) | (ValidD & (UsesHiLoD | DivStartD) & DivBusy).
- StallF = StallD = FlushE = Stall.
- FlushDIn takes priority over Stall for E insertion: a bubble is inserted either way. Stall outputs still follow the combinational equation.

## Timing
- All outputs are combinational from shadow state plus D inputs. There is no registered output latency.
- A shadow update becomes visible in the cycle after the edge.
- Reset: all Valid*, RegWrite*, MemtoReg*, WriteReg* are 0 and cnt = 0. Therefore every Forward*, Stall*, FlushE and DivBusy output is 0 in the cycle after reset.
- Reset asserted mid-divide clears cnt immediately. Reset overrides all updates.
- Load-use costs 2 stall cycles when the load is in E: the load moves E->M, the stall persists, then M->W, and N2 is selected. A load already in M costs 1 stall cycle.
- Divide: issue at cycle t. cnt = DIV_LATENCY at t+1 and reaches 0 at t+1+DIV_LATENCY. mfhi stalls until DivBusy=0.
- A back-to-back DivStartD while busy stalls and does not reload until busy clears.
- Register $0 never matches, so it never forwards or stalls.

## Test plan
- Reset test: hold reset 2 cycles with random inputs. Every output must read 0, and the first compare after release uses empty shadows, so nothing forwards.
- Sequence add $3 then sub $4,$3,$5 -> ForwardADN1=1 for one cycle, no stall. Inserting one nop instead gives ForwardAD=1. Two nops give ForwardADN2=1.
- Sequence lw $2 then add $6,$2,$2 -> StallF=StallD=FlushE=1 for 2 cycles, then ForwardADN2=ForwardBDN2=1 with no stall.
- $7 is written in E, M and W simultaneously (three writes to $7), consumer uses Rt=$7 -> only ForwardBDN1=1. ForwardBD=ForwardBDN2=0.
- div issued, then mflo next, with DIV_LATENCY=8 -> Stall high for exactly 8 cycles. DivBusy then falls, and mflo proceeds the following cycle.
- Divide in progress with cnt=5, assert reset -> DivBusy=0 the next cycle. FlushDIn with a RegWriteD producer -> no forward to the following instruction from that slot.

Source files
------------

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Purpose  : Decode-stage forwarding select, load-use and divider-busy stall
//            control for the 5-stage MIPS pipeline, driven by shadow E/M/W state.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int DIV_LATENCY = 8,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ValidD,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic       UsesRsD,
    input  logic       UsesRtD,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic [4:0] WriteRegD,
    input  logic       DivStartD,
    input  logic       UsesHiLoD,
    input  logic       FlushDIn,
    output logic       ForwardADN1,
    output logic       ForwardBDN1,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       ForwardADN2,
    output logic       ForwardBDN2,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       DivBusy
);

    localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             r_valid_e, r_regwrite_e, r_memtoreg_e;
    logic [4:0]       r_writereg_e;
    logic             r_valid_m, r_regwrite_m, r_memtoreg_m;
    logic [4:0]       r_writereg_m;
    // The W-stage load flag is not kept: ResultW already carries load data.
    logic             r_valid_w, r_regwrite_w;
    logic [4:0]       r_writereg_w;
    logic [CNT_W-1:0] r_div_cnt;

    logic w_a_e, w_a_m, w_a_w, w_b_e, w_b_m, w_b_w;
    logic w_a_n1, w_a_m_fwd, w_a_n2, w_a_lu;
    logic w_b_n1, w_b_m_fwd, w_b_n2, w_b_lu;
    logic w_div_busy, w_stall, w_div_issue;

    function automatic logic src_match(
        input logic       valid_x,
        input logic       regwrite_x,
        input logic [4:0] writereg_x,
        input logic [4:0] src,
        input logic       uses,
        input logic       valid_d
    );
        return valid_x & regwrite_x & (writereg_x == src) & (src != 5'd0) & uses & valid_d;
    endfunction

    always_comb begin
        w_a_e = src_match(r_valid_e, r_regwrite_e, r_writereg_e, RsD, UsesRsD, ValidD);
        w_a_m = src_match(r_valid_m, r_regwrite_m, r_writereg_m, RsD, UsesRsD, ValidD);
        w_a_w = src_match(r_valid_w, r_regwrite_w, r_writereg_w, RsD, UsesRsD, ValidD);
        w_b_e = src_match(r_valid_e, r_regwrite_e, r_writereg_e, RtD, UsesRtD, ValidD);
        w_b_m = src_match(r_valid_m, r_regwrite_m, r_writereg_m, RtD, UsesRtD, ValidD);
        w_b_w = src_match(r_valid_w, r_regwrite_w, r_writereg_w, RtD, UsesRtD, ValidD);

        // Youngest producer wins; a load in E or M blocks older matches entirely.
        w_a_n1    = w_a_e & ~r_memtoreg_e;
        w_a_m_fwd = ~w_a_e & w_a_m & ~r_memtoreg_m;
        w_a_n2    = ~w_a_e & ~w_a_m & w_a_w;
        w_a_lu    = (w_a_e & r_memtoreg_e) | (~w_a_e & w_a_m & r_memtoreg_m);

        w_b_n1    = w_b_e & ~r_memtoreg_e;
        w_b_m_fwd = ~w_b_e & w_b_m & ~r_memtoreg_m;
        w_b_n2    = ~w_b_e & ~w_b_m & w_b_w;
        w_b_lu    = (w_b_e & r_memtoreg_e) | (~w_b_e & w_b_m & r_memtoreg_m);

        w_div_busy  = (r_div_cnt != '0);
        w_stall     = w_a_lu | w_b_lu | (ValidD & (UsesHiLoD | DivStartD) & w_div_busy);
        w_div_issue = DivStartD & ValidD & ~w_stall & ~FlushDIn;
    end

    assign ForwardADN1 = w_a_n1;
    assign ForwardAD   = w_a_m_fwd;
    assign ForwardADN2 = w_a_n2;
    assign ForwardBDN1 = w_b_n1;
    assign ForwardBD   = w_b_m_fwd;
    assign ForwardBDN2 = w_b_n2;
    assign StallF      = w_stall;
    assign StallD      = w_stall;
    assign FlushE      = w_stall;
    assign DivBusy     = w_div_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_e    <= 1'b0;
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_writereg_e <= 5'd0;
            r_valid_m    <= 1'b0;
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_writereg_m <= 5'd0;
            r_valid_w    <= 1'b0;
            r_regwrite_w <= 1'b0;
            r_writereg_w <= 5'd0;
            r_div_cnt    <= '0;
        end else begin
            r_valid_m    <= r_valid_e;
            r_regwrite_m <= r_regwrite_e;
            r_memtoreg_m <= r_memtoreg_e;
            r_writereg_m <= r_writereg_e;
            r_valid_w    <= r_valid_m;
            r_regwrite_w <= r_regwrite_m;
            r_writereg_w <= r_writereg_m;

            if (w_stall || FlushDIn) begin
                r_valid_e    <= 1'b0;
                r_regwrite_e <= 1'b0;
                r_memtoreg_e <= 1'b0;
                r_writereg_e <= 5'd0;
            end else begin
                r_valid_e    <= ValidD;
                r_regwrite_e <= RegWriteD;
                r_memtoreg_e <= MemtoRegD;
                r_writereg_e <= WriteRegD;
            end

            if (w_div_issue) begin
                r_div_cnt <= c_DIV_LOAD;
            end else if (w_div_busy) begin
                r_div_cnt <= r_div_cnt - c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit
// Purpose  : Directed, table-driven checks of forwarding, stalls and divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ValidD, UsesRsD, UsesRtD, RegWriteD, MemtoRegD, DivStartD, UsesHiLoD, FlushDIn;
    logic [4:0] RsD, RtD, WriteRegD;
    logic       ForwardADN1, ForwardBDN1, ForwardAD, ForwardBD, ForwardADN2, ForwardBDN2;
    logic       StallF, StallD, FlushE, DivBusy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.DIV_LATENCY(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .ValidD(ValidD), .RsD(RsD), .RtD(RtD),
        .UsesRsD(UsesRsD), .UsesRtD(UsesRtD), .RegWriteD(RegWriteD),
        .MemtoRegD(MemtoRegD), .WriteRegD(WriteRegD), .DivStartD(DivStartD),
        .UsesHiLoD(UsesHiLoD), .FlushDIn(FlushDIn),
        .ForwardADN1(ForwardADN1), .ForwardBDN1(ForwardBDN1),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardADN2(ForwardADN2), .ForwardBDN2(ForwardBDN2),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .DivBusy(DivBusy)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic       urs, urt, rw, mem;
        logic [4:0] wr;
        logic       ds, hl, fl;
        logic [5:0] fwd;     // {ADN1, BDN1, AD, BD, ADN2, BDN2}
        logic       stall;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic valid, input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt, input logic rw, input logic mem,
        input logic [4:0] wr, input logic ds, input logic hl, input logic fl,
        input logic [5:0] fwd, input logic stall, input logic busy
    );
        vec_t v;
        v.valid = valid; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.rw = rw; v.mem = mem; v.wr = wr; v.ds = ds; v.hl = hl; v.fl = fl;
        v.fwd = fwd; v.stall = stall; v.busy = busy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ValidD = v.valid; RsD = v.rs; RtD = v.rt; UsesRsD = v.urs; UsesRtD = v.urt;
        RegWriteD = v.rw; MemtoRegD = v.mem; WriteRegD = v.wr;
        DivStartD = v.ds; UsesHiLoD = v.hl; FlushDIn = v.fl;
    endtask

    task automatic check(input string name, input logic [5:0] fwd, input logic stall, input logic busy);
        logic [5:0] got_fwd;
        logic [2:0] got_st;
        got_fwd = {ForwardADN1, ForwardBDN1, ForwardAD, ForwardBD, ForwardADN2, ForwardBDN2};
        got_st  = {StallF, StallD, FlushE};
        checks++;
        if (got_fwd !== fwd) begin
            errors++;
            $display("FAIL %s fwd: got %b expected %b", name, got_fwd, fwd);
        end
        checks++;
        if (got_st !== {3{stall}}) begin
            errors++;
            $display("FAIL %s stall{F,D,FlushE}: got %b expected %b", name, got_st, {3{stall}});
        end
        checks++;
        if (DivBusy !== busy) begin
            errors++;
            $display("FAIL %s DivBusy: got %b expected %b", name, DivBusy, busy);
        end
    endtask

    initial begin
        vec_t nop;
        vec_t v;
        nop = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);

        // add/sub forwarding distances
        tbl.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 0, 0, 6'b000000, 0, 0));
        tbl.push_back(mk(1, 3, 5, 1, 1, 1, 0, 4, 0, 0, 0, 6'b100000, 0, 0));
        tbl.push_back(mk(1, 3, 5, 1, 1, 1, 0, 8, 0, 0, 0, 6'b001000, 0, 0));
        tbl.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 6'b000110, 0, 0));
        tbl.push_back(nop);
        // load in E: two stall cycles then ResultW
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0, 6'b000000, 0, 0));
        tbl.push_back(mk(1, 2, 2, 1, 1, 1, 0, 6, 0, 0, 0, 6'b000000, 1, 0));
        tbl.push_back(mk(1, 2, 2, 1, 1, 1, 0, 6, 0, 0, 0, 6'b000000, 1, 0));
        tbl.push_back(mk(1, 2, 2, 1, 1, 1, 0, 6, 0, 0, 0, 6'b000011, 0, 0));
        // $7 written in E, M and W at once
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 6'b000000, 0, 0));
        tbl.push_back(mk(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 6'b010000, 0, 0));
        // load to $0 never stalls
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 6'b000000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
        // flushed producer of $9 must not forward
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 9, 0, 0, 1, 6'b000000, 0, 0));
        tbl.push_back(mk(1, 9, 9, 1, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
        // load already in M: one stall cycle
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 10, 0, 0, 0, 6'b000000, 0, 0));
        tbl.push_back(nop);
        tbl.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0));
        tbl.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000010, 0, 0));
        // div then mflo: 8 stall cycles
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000000, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11, 0, 1, 0, 6'b000000, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11, 0, 1, 0, 6'b000000, 0, 0));
        tbl.push_back(mk(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 0, 0));
        // back-to-back div waits, no reload while busy
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000000, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000000, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 1));

        // reset for two cycles with random inputs
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v = mk($urandom_range(0, 1), 5'($urandom), 5'($urandom), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   5'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), 6'b0, 0, 0);
            drive(v);
            @(posedge clk); #1;
        end
        check("reset", 6'b000000, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].fwd, tbl[i].stall, tbl[i].busy);
            @(posedge clk); #1;
        end

        // counter now at 6; one more nop brings it to 5, then reset mid-divide
        drive(nop);
        @(negedge clk);
        check("div_cnt6", 6'b000000, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("div_cnt5", 6'b000000, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b0, 0, 0));
        @(negedge clk);
        check("reset_mid_div", 6'b000000, 1'b0, 1'b0);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
